// File: rtl/tank_ctrl_pkg.sv
// tank_pkg: shared HID key codes, fire-state encoding, sign-magnitude trig type and clamp helper
package tank_pkg;
  localparam logic [7:0] HID_UP = 8'h52, HID_DN = 8'h51, HID_L = 8'h50, HID_R = 8'h4f, HID_FIRE = 8'h2c;
  typedef enum logic [1:0] {F_IDLE, F_SHOT, F_COOL, F_HOLD} fire_state_e;
  typedef struct packed {
    logic       sgn;
    logic [6:0] mag;
  } trig_t;
  function automatic logic [9:0] clamp(input logic signed [10:0] v, input logic signed [10:0] lo, input logic signed [10:0] hi);
    return v < lo ? lo[9:0] : v > hi ? hi[9:0] : v[9:0];
  endfunction
endpackage

// File: rtl/tank_ctrl_if.sv
// tank_if: tank controller bus
//   keycode/sin/cos flow from master to slave; TankX/TankY/TankS/Angle/ShootBullet/FireReady flow back
interface tank_if #(parameter int NKEYS = 4);
  import tank_pkg::*;
  logic [8*NKEYS-1:0] keycode;
  trig_t              sin, cos;
  logic [9:0]         TankX, TankY, TankS;
  logic [5:0]         Angle;
  logic               ShootBullet, FireReady;
  modport master(output keycode, sin, cos, input TankX, TankY, TankS, Angle, ShootBullet, FireReady);
  modport slave(input keycode, sin, cos, output TankX, TankY, TankS, Angle, ShootBullet, FireReady);
endinterface

// File: rtl/tank_ctrl_key_match.sv
// key_match: high when any keycode byte slot holds code_i
//   keycode_i: NKEYS packed HID bytes; code_i: key to look for; pressed_o: match flag
module key_match #(parameter int NKEYS = 4) (
  input  logic [8*NKEYS-1:0] keycode_i,
  input  logic [7:0]         code_i,
  output logic               pressed_o
);
  always_comb begin
    pressed_o = 1'b0;
    for (int i = 0; i < NKEYS; i++) pressed_o |= keycode_i[8*i +: 8] == code_i;
  end
endmodule

// File: rtl/tank.sv
// tank_ctrl: per-frame tank movement, rotation and fire control
//   frame_clk: one edge per frame; Reset_n: async active-low reset
//   bus (tank_if.slave): keycode/sin/cos in; TankX/TankY/TankS/Angle/ShootBullet/FireReady out
//   TANK_AUTOFIRE_EN: when defined, a held FIRE re-fires every COOLDOWN+1 frames instead of waiting for release
module tank_ctrl import tank_pkg::*; #(
  parameter int         X_CENTER    = 300,
  parameter int         Y_CENTER    = 250,
  parameter int         X_MIN       = 0,
  parameter int         X_MAX       = 639,
  parameter int         Y_MIN       = 0,
  parameter int         Y_MAX       = 479,
  parameter int         SIZE        = 10,
  parameter logic [6:0] STEP        = 7'd80,
  parameter int         ANGLE_STEPS = 45,
  parameter logic [7:0] KEY_UP      = HID_UP,
  parameter logic [7:0] KEY_DN      = HID_DN,
  parameter logic [7:0] KEY_L       = HID_L,
  parameter logic [7:0] KEY_R       = HID_R,
  parameter logic [7:0] KEY_FIRE    = HID_FIRE,
  parameter int         NKEYS       = 4,
  parameter int         COOLDOWN    = 30
) (
  input logic  frame_clk,
  input logic  Reset_n,
  tank_if.slave bus
);
  localparam int CW = $clog2(COOLDOWN + 1);
  localparam logic [1:0] IDLE = F_IDLE, SHOT = F_SHOT, COOL = F_COOL, HOLD = F_HOLD;
`ifdef TANK_AUTOFIRE_EN
  localparam logic [1:0] REFIRE = SHOT;
`else
  localparam logic [1:0] REFIRE = HOLD;
`endif
  localparam logic signed [10:0] XLO = 11'(X_MIN + SIZE), XHI = 11'(X_MAX - SIZE);
  localparam logic signed [10:0] YLO = 11'(Y_MIN + SIZE), YHI = 11'(Y_MAX - SIZE);
  localparam logic [5:0] AMAX = 6'(ANGLE_STEPS - 1);
  logic up_q, dn_q, l_q, r_q, fire_q, up_d, dn_d, l_d, r_d, fire_d;
  logic [9:0] x_q, y_q, x_d, y_d;
  logic [5:0] a_q, a_d;
  logic [1:0] st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0] dxm, dym;
  logic signed [10:0] sx, sy, mx, my;
  logic mv;
  key_match #(.NKEYS(NKEYS)) u_up  (.keycode_i(bus.keycode), .code_i(KEY_UP),   .pressed_o(up_d));
  key_match #(.NKEYS(NKEYS)) u_dn  (.keycode_i(bus.keycode), .code_i(KEY_DN),   .pressed_o(dn_d));
  key_match #(.NKEYS(NKEYS)) u_l   (.keycode_i(bus.keycode), .code_i(KEY_L),    .pressed_o(l_d));
  key_match #(.NKEYS(NKEYS)) u_r   (.keycode_i(bus.keycode), .code_i(KEY_R),    .pressed_o(r_d));
  key_match #(.NKEYS(NKEYS)) u_fire(.keycode_i(bus.keycode), .code_i(KEY_FIRE), .pressed_o(fire_d));
  // Forward motion: cos sign picks X direction; positive sin moves up the screen (Y decreases)
  always_comb begin
    dxm = 7'((14'(STEP) * 14'(bus.cos.mag)) >> 7);
    dym = 7'((14'(STEP) * 14'(bus.sin.mag)) >> 7);
    sx  = bus.cos.sgn ? -$signed({4'b0, dxm}) : $signed({4'b0, dxm});
    sy  = bus.sin.sgn ? $signed({4'b0, dym}) : -$signed({4'b0, dym});
    mv  = up_q ^ dn_q;
    mx  = !mv ? 11'sd0 : dn_q ? -sx : sx;
    my  = !mv ? 11'sd0 : dn_q ? -sy : sy;
    x_d = clamp($signed({1'b0, x_q}) + mx, XLO, XHI);
    y_d = clamp($signed({1'b0, y_q}) + my, YLO, YHI);
    a_d = (l_q && !r_q) ? (a_q == AMAX ? 6'd0 : a_q + 6'd1) :
          (r_q && !l_q) ? (a_q == 6'd0 ? AMAX : a_q - 6'd1) : a_q;
  end
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    case (st_q)
      IDLE: st_d = fire_q ? SHOT : IDLE;
      SHOT: begin
        st_d  = COOL;
        cnt_d = CW'(COOLDOWN - 1);
      end
      COOL: begin
        st_d  = cnt_q != '0 ? COOL : fire_q ? REFIRE : IDLE;
        cnt_d = cnt_q != '0 ? cnt_q - 1'b1 : cnt_q;
      end
      default: st_d = fire_q ? HOLD : IDLE;
    endcase
  end
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      {up_q, dn_q, l_q, r_q, fire_q} <= '0;
      x_q   <= 10'(X_CENTER);
      y_q   <= 10'(Y_CENTER);
      a_q   <= '0;
      st_q  <= IDLE;
      cnt_q <= '0;
    end else begin
      {up_q, dn_q, l_q, r_q, fire_q} <= {up_d, dn_d, l_d, r_d, fire_d};
      x_q   <= x_d;
      y_q   <= y_d;
      a_q   <= a_d;
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.TankX       = x_q;
  assign bus.TankY       = y_q;
  assign bus.TankS       = 10'(SIZE);
  assign bus.Angle       = a_q;
  assign bus.ShootBullet = st_q == SHOT;
  assign bus.FireReady   = st_q == IDLE;
endmodule

// File: tb/tb_tank_ctrl.sv
// tb_tank_ctrl: directed self-checking bench for tank_ctrl
module tb_tank_ctrl;
  import tank_pkg::*;
  logic clk = 1'b0, rst_n = 1'b1;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  tank_if #(.NKEYS(4)) bus();
  tank_ctrl dut(.frame_clk(clk), .Reset_n(rst_n), .bus(bus));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    bus.keycode = '0; bus.sin = 8'h00; bus.cos = 8'h00;
    #1 rst_n = 1'b0;
    #2;
    if (bus.TankX !== 10'd300) begin failures++; $display("FAIL reset_x got=%0d exp=300", bus.TankX); end checks++;
    if (bus.TankY !== 10'd250) begin failures++; $display("FAIL reset_y got=%0d exp=250", bus.TankY); end checks++;
    if (bus.Angle !== 6'd0) begin failures++; $display("FAIL reset_angle got=%0d exp=0", bus.Angle); end checks++;
    if (bus.FireReady !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", bus.FireReady); end checks++;
    if (bus.ShootBullet !== 1'b0) begin failures++; $display("FAIL reset_shoot got=%0b exp=0", bus.ShootBullet); end checks++;
    if (bus.TankS !== 10'd10) begin failures++; $display("FAIL reset_size got=%0d exp=10", bus.TankS); end checks++;
    step(); step();
    rst_n = 1'b1;
    step();
    if (bus.TankX !== 10'd300) begin failures++; $display("FAIL idle_x got=%0d exp=300", bus.TankX); end checks++;
  endtask

  task automatic test_move_x();
    int x = 300;
    bus.cos = 8'h7F; bus.sin = 8'h00;
    bus.keycode = {8'h00, HID_UP, 8'h00, 8'h00};
    step();
    if (bus.TankX !== 10'd300) begin failures++; $display("FAIL latency_x got=%0d exp=300", bus.TankX); end checks++;
    for (int i = 0; i < 10; i++) begin
      step();
      x = (x + 79 > 629) ? 629 : x + 79;
      if (bus.TankX !== 10'(x)) begin failures++; $display("FAIL fwd_x[%0d] got=%0d exp=%0d", i, bus.TankX, x); end checks++;
      if (bus.TankY !== 10'd250) begin failures++; $display("FAIL fwd_y[%0d] got=%0d exp=250", i, bus.TankY); end checks++;
    end
    bus.keycode = '0;
    step(); step();
    if (bus.TankX !== 10'd629) begin failures++; $display("FAIL hold_x got=%0d exp=629", bus.TankX); end checks++;
    bus.keycode = {HID_DN, 8'h00, 8'h00, 8'h00};
    step();
    for (int i = 0; i < 8; i++) begin
      step();
      x = (x - 79 < 10) ? 10 : x - 79;
      if (bus.TankX !== 10'(x)) begin failures++; $display("FAIL rev_x[%0d] got=%0d exp=%0d", i, bus.TankX, x); end checks++;
    end
    bus.keycode = '0;
    step(); step();
    if (bus.TankX !== 10'd10) begin failures++; $display("FAIL low_clamp_x got=%0d exp=10", bus.TankX); end checks++;
  endtask

  task automatic test_move_y();
    int y = 250;
    bus.cos = 8'h00; bus.sin = 8'h7F;
    bus.keycode = {8'h00, 8'h00, 8'h00, HID_UP};
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      y = (y - 79 < 10) ? 10 : y - 79;
      if (bus.TankY !== 10'(y)) begin failures++; $display("FAIL up_y[%0d] got=%0d exp=%0d", i, bus.TankY, y); end checks++;
      if (bus.TankX !== 10'd10) begin failures++; $display("FAIL up_x[%0d] got=%0d exp=10", i, bus.TankX); end checks++;
    end
    bus.sin = 8'hFF;
    step();
    if (bus.TankY !== 10'd89) begin failures++; $display("FAIL neg_sin_y got=%0d exp=89", bus.TankY); end checks++;
    bus.keycode = '0;
    step(); step();
    if (bus.TankY !== 10'd168) begin failures++; $display("FAIL release_y got=%0d exp=168", bus.TankY); end checks++;
    bus.sin = 8'h00;
  endtask

  task automatic test_rotate();
    bus.keycode = {8'h00, 8'h00, HID_R, 8'h00};
    step();
    if (bus.Angle !== 6'd0) begin failures++; $display("FAIL rot_latency got=%0d exp=0", bus.Angle); end checks++;
    step();
    if (bus.Angle !== 6'd44) begin failures++; $display("FAIL rot_wrap_down got=%0d exp=44", bus.Angle); end checks++;
    bus.keycode = '0;
    step(); step();
    if (bus.Angle !== 6'd43) begin failures++; $display("FAIL rot_r_release got=%0d exp=43", bus.Angle); end checks++;
    bus.keycode = {8'h00, HID_L, 8'h00, 8'h00};
    step(); step();
    if (bus.Angle !== 6'd44) begin failures++; $display("FAIL rot_l got=%0d exp=44", bus.Angle); end checks++;
    step();
    if (bus.Angle !== 6'd0) begin failures++; $display("FAIL rot_wrap_up got=%0d exp=0", bus.Angle); end checks++;
    bus.keycode = {HID_L, HID_R, 8'h00, 8'h00};
    step(); step();
    if (bus.Angle !== 6'd1) begin failures++; $display("FAIL rot_lr_hold got=%0d exp=1", bus.Angle); end checks++;
    bus.keycode = '0;
    step(); step();
  endtask

  task automatic test_combo();
    bus.cos = 8'h40; bus.sin = 8'h00;
    bus.keycode = {HID_L, 8'h00, 8'h00, HID_UP};
    step();
    step();
    if (bus.TankX !== 10'd50) begin failures++; $display("FAIL combo_x got=%0d exp=50", bus.TankX); end checks++;
    if (bus.Angle !== 6'd2) begin failures++; $display("FAIL combo_angle got=%0d exp=2", bus.Angle); end checks++;
    bus.keycode = {HID_UP, HID_DN, 8'h00, 8'h00};
    step();
    if (bus.TankX !== 10'd90) begin failures++; $display("FAIL combo_x2 got=%0d exp=90", bus.TankX); end checks++;
    step(); step();
    if (bus.TankX !== 10'd90) begin failures++; $display("FAIL updn_x got=%0d exp=90", bus.TankX); end checks++;
    if (bus.Angle !== 6'd3) begin failures++; $display("FAIL updn_angle got=%0d exp=3", bus.Angle); end checks++;
    bus.keycode = {HID_UP, HID_FIRE, 8'h00, HID_DN};
    step(); step();
    if (bus.TankX !== 10'd90) begin failures++; $display("FAIL updn_fire_x got=%0d exp=90", bus.TankX); end checks++;
    bus.keycode = '0;
    bus.cos = 8'h00;
    for (int e = 0; e < 40; e++) step();
    if (bus.FireReady !== 1'b1) begin failures++; $display("FAIL combo_settle got=%0b exp=1", bus.FireReady); end checks++;
  endtask

  task automatic test_fire_tap();
    bus.keycode = {8'h00, 8'h00, 8'h00, HID_FIRE};
    step();
    if (bus.ShootBullet !== 1'b0) begin failures++; $display("FAIL tap_latency got=%0b exp=0", bus.ShootBullet); end checks++;
    bus.keycode = '0;
    step();
    if (bus.ShootBullet !== 1'b1) begin failures++; $display("FAIL tap_shot got=%0b exp=1", bus.ShootBullet); end checks++;
    if (bus.FireReady !== 1'b0) begin failures++; $display("FAIL tap_ready_shot got=%0b exp=0", bus.FireReady); end checks++;
    for (int e = 3; e <= 33; e++) begin
      step();
      if (bus.ShootBullet !== 1'b0) begin failures++; $display("FAIL tap_cool_shoot[%0d] got=%0b exp=0", e, bus.ShootBullet); end checks++;
      if (bus.FireReady !== (e >= 33)) begin failures++; $display("FAIL tap_ready[%0d] got=%0b exp=%0b", e, bus.FireReady, e >= 33); end checks++;
    end
  endtask

  task automatic test_fire_hold();
    int pulses = 0, first = 0, second = 0, exp_pulses;
`ifdef TANK_AUTOFIRE_EN
    exp_pulses = 4;
`else
    exp_pulses = 1;
`endif
    bus.keycode = {8'h00, HID_FIRE, 8'h00, 8'h00};
    for (int e = 1; e <= 100; e++) begin
      step();
      if (bus.ShootBullet === 1'b1) begin
        pulses++;
        if (pulses == 1) first = e;
        if (pulses == 2) second = e;
      end
    end
    if (pulses !== exp_pulses) begin failures++; $display("FAIL hold_pulses got=%0d exp=%0d", pulses, exp_pulses); end checks++;
    if (first !== 2) begin failures++; $display("FAIL hold_first got=%0d exp=2", first); end checks++;
    if (second !== (exp_pulses > 1 ? 33 : 0)) begin failures++; $display("FAIL hold_second got=%0d exp=%0d", second, exp_pulses > 1 ? 33 : 0); end checks++;
    if (bus.FireReady !== 1'b0) begin failures++; $display("FAIL hold_ready got=%0b exp=0", bus.FireReady); end checks++;
    bus.keycode = '0;
    for (int e = 0; e < 40; e++) step();
    if (bus.FireReady !== 1'b1) begin failures++; $display("FAIL hold_release_ready got=%0b exp=1", bus.FireReady); end checks++;
  endtask

  task automatic test_reset_cool();
    bus.keycode = {8'h00, 8'h00, 8'h00, HID_FIRE};
    step(); step();
    if (bus.ShootBullet !== 1'b1) begin failures++; $display("FAIL rc_shot got=%0b exp=1", bus.ShootBullet); end checks++;
    bus.keycode = '0;
    step(); step();
    if (bus.FireReady !== 1'b0) begin failures++; $display("FAIL rc_cool got=%0b exp=0", bus.FireReady); end checks++;
    rst_n = 1'b0;
    #2;
    if (bus.FireReady !== 1'b1) begin failures++; $display("FAIL rc_reset_ready got=%0b exp=1", bus.FireReady); end checks++;
    if (bus.TankX !== 10'd300) begin failures++; $display("FAIL rc_reset_x got=%0d exp=300", bus.TankX); end checks++;
    if (bus.TankS !== 10'd10) begin failures++; $display("FAIL rc_reset_size got=%0d exp=10", bus.TankS); end checks++;
    rst_n = 1'b1;
    bus.keycode = {8'h00, 8'h00, 8'h00, HID_FIRE};
    step();
    if (bus.ShootBullet !== 1'b0) begin failures++; $display("FAIL rc_refire_latency got=%0b exp=0", bus.ShootBullet); end checks++;
    step();
    if (bus.ShootBullet !== 1'b1) begin failures++; $display("FAIL rc_refire got=%0b exp=1", bus.ShootBullet); end checks++;
    bus.keycode = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_move_x();
    test_move_y();
    test_rotate();
    test_combo();
    test_fire_tap();
    test_fire_hold();
    test_reset_cool();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
